// File: rtl/rw_sched_pkg.sv
// Shared types for the two-context step scheduler: FSM state encoding,
// context id type and the width of the optional step counters.
package rw_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef logic ctx_id_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/rw_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last context that
// was actually accepted; on a tie the other context wins. After reset the
// pointer says "context 1 went last" so context 0 wins the first tie.
module rw_rr_arb2
  import rw_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_elig,
  input  logic       i_accept,
  output logic       o_gnt_valid,
  output ctx_id_t    o_gnt
);

  ctx_id_t r_last;

  // Pick the winner from the eligible set and the last-granted pointer.
  // NOTE: every output of a combinational block is given a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    o_gnt_valid = |i_elig;
    o_gnt       = 1'b0;
    if (i_elig == 2'b11) begin
      o_gnt = ~r_last;
    end else if (i_elig[1]) begin
      o_gnt = 1'b1;
    end
  end

  // Advance the pointer only when the grant is consumed.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_accept) begin
      r_last <= o_gnt;
    end
  end

endmodule

// File: rtl/rw_ctx_sched.sv
// Time-shares one combinational step core between two contexts.
// Each context owns a state register, a halted flag and a response slot.
// Optional feature: define RW_CTX_SCHED_STATS_EN to add per-context
// 16-bit step counters (step_cnt0, step_cnt1).
module rw_ctx_sched
  import rw_sched_pkg::*;
#(
  parameter int unsigned      IN_W    = 1,
  parameter int unsigned      OUT_W   = 1,
  parameter int unsigned      ST_W    = 1,
  parameter logic [ST_W-1:0]  ST_INIT = ST_W'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [IN_W-1:0]  req0_data,
  input  logic [IN_W-1:0]  req1_data,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [OUT_W-1:0] resp0_data,
  output logic [OUT_W-1:0] resp1_data,
  output logic             resp0_cont,
  output logic             resp1_cont,
  input  logic             resp0_ready,
  input  logic             resp1_ready,
  output logic [IN_W-1:0]  dev_in,
  output logic [ST_W-1:0]  dev_st,
  input  logic [OUT_W-1:0] dev_out,
  input  logic [ST_W-1:0]  dev_st_next,
  input  logic             dev_cont,
`ifdef RW_CTX_SCHED_STATS_EN
  output logic [CNT_W-1:0] step_cnt0,
  output logic [CNT_W-1:0] step_cnt1,
`endif
  output logic [1:0]       halted
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  ctx_id_t                 r_ctx;
  logic [IN_W-1:0]         r_in;
  logic [ST_W-1:0]         r_dev_st;
  logic [1:0][ST_W-1:0]    r_st;
  logic [1:0][OUT_W-1:0]   r_resp_data;
  logic [1:0]              r_resp_cont;
  logic [1:0]              r_resp_valid;
  logic [1:0]              r_halted;

  logic [1:0]              w_req_valid;
  logic [1:0]              w_resp_ready;
  logic [1:0]              w_elig;
  logic [1:0]              w_req_ready;
  logic                    w_gnt_valid;
  ctx_id_t                 w_gnt;
  logic                    w_accept;

  assign w_req_valid  = {req1_valid, req0_valid};
  assign w_resp_ready = {resp1_ready, resp0_ready};
  // A halted context never competes for the core.
  assign w_elig       = w_req_valid & ~r_halted;

  rw_rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_elig      (w_elig),
    .i_accept    (w_accept),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt       (w_gnt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; requests are only taken in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 2'b00;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_valid) begin
          w_req_ready[w_gnt] = 1'b1;
          w_accept           = 1'b1;
          w_state_nxt        = S_STEP;
        end
      end
      S_STEP: w_state_nxt = S_RESP;
      S_RESP: begin
        if (r_resp_valid[r_ctx] && w_resp_ready[r_ctx]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the request, run the core for one cycle, then hold the response.
  // NOTE: the per-context state array is reset explicitly because every context must restart from ST_INIT; it is two words, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctx        <= 1'b0;
      r_in         <= '0;
      r_dev_st     <= '0;
      r_st         <= {2{ST_INIT}};
      r_resp_data  <= '0;
      r_resp_cont  <= '0;
      r_resp_valid <= '0;
      r_halted     <= '0;
    end else begin
      if (w_accept) begin
        r_ctx    <= w_gnt;
        r_in     <= w_gnt ? req1_data : req0_data;
        r_dev_st <= r_st[w_gnt];
      end
      if (r_state == S_STEP) begin
        r_st[r_ctx]         <= dev_st_next;
        r_resp_data[r_ctx]  <= dev_out;
        r_resp_cont[r_ctx]  <= dev_cont;
        r_resp_valid[r_ctx] <= 1'b1;
        if (!dev_cont) begin
          r_halted[r_ctx] <= 1'b1;
        end
      end
      if ((r_state == S_RESP) && w_resp_ready[r_ctx]) begin
        r_resp_valid[r_ctx] <= 1'b0;
      end
    end
  end

  assign req0_ready  = w_req_ready[0];
  assign req1_ready  = w_req_ready[1];
  assign resp0_valid = r_resp_valid[0];
  assign resp1_valid = r_resp_valid[1];
  assign resp0_data  = r_resp_data[0];
  assign resp1_data  = r_resp_data[1];
  assign resp0_cont  = r_resp_cont[0];
  assign resp1_cont  = r_resp_cont[1];
  // Core inputs come from registers loaded at acceptance, so they hold
  // their last values whenever the core is not in use.
  assign dev_in      = r_in;
  assign dev_st      = r_dev_st;
  assign halted      = r_halted;

`ifdef RW_CTX_SCHED_STATS_EN
  logic [CNT_W-1:0] r_step_cnt0;
  logic [CNT_W-1:0] r_step_cnt1;

  // Count STEP cycles per context; wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_cnt0 <= '0;
      r_step_cnt1 <= '0;
    end else if (r_state == S_STEP) begin
      if (r_ctx) begin
        r_step_cnt1 <= r_step_cnt1 + CNT_W'(1);
      end else begin
        r_step_cnt0 <= r_step_cnt0 + CNT_W'(1);
      end
    end
  end

  assign step_cnt0 = r_step_cnt0;
  assign step_cnt1 = r_step_cnt1;
`endif

endmodule

// File: tb/tb_rw_ctx_sched.sv
// Self-checking bench for rw_ctx_sched. A small step core model drives the
// dev_* inputs; a scoreboard records the expected response at acceptance
// and checks it when the response appears.
module tb_rw_ctx_sched;
  import rw_sched_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready;
  logic         resp0_valid, resp1_valid;
  logic [W-1:0] resp0_data, resp1_data;
  logic         resp0_cont, resp1_cont;
  logic         resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic [W-1:0] dev_in, dev_st, dev_out, dev_st_next;
  logic         dev_cont;
  logic [1:0]   halted;
`ifdef RW_CTX_SCHED_STATS_EN
  logic [CNT_W-1:0] step_cnt0, step_cnt1;
`endif

  // Step core model: next state = st ^ in, out = in + st - 1, halt on 0xFF.
  assign dev_st_next = dev_st ^ dev_in;
  assign dev_out     = dev_in + dev_st - 8'd1;
  assign dev_cont    = (dev_in != 8'hFF);

  rw_ctx_sched #(.IN_W(W), .OUT_W(W), .ST_W(W), .ST_INIT(8'h01)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .req0_data   (req0_data),
    .req1_data   (req1_data),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .resp0_valid (resp0_valid),
    .resp1_valid (resp1_valid),
    .resp0_data  (resp0_data),
    .resp1_data  (resp1_data),
    .resp0_cont  (resp0_cont),
    .resp1_cont  (resp1_cont),
    .resp0_ready (resp0_ready),
    .resp1_ready (resp1_ready),
    .dev_in      (dev_in),
    .dev_st      (dev_st),
    .dev_out     (dev_out),
    .dev_st_next (dev_st_next),
    .dev_cont    (dev_cont),
`ifdef RW_CTX_SCHED_STATS_EN
    .step_cnt0   (step_cnt0),
    .step_cnt1   (step_cnt1),
`endif
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ctx;
    logic [W-1:0] data;
    logic         cont;
    int           acc_cyc;
  } exp_t;

  exp_t         sb[$];
  int           gnt_log[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_accept = 0;
  int           cyc = 0;
  logic [W-1:0] m_st[2];
  logic [1:0]   prev_rv = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: push on acceptance, compare each cycle a response is valid.
  always @(negedge clk) begin
    logic [1:0] rv, rr, qv, qr;
    rv = {resp1_valid, resp0_valid};
    rr = {resp1_ready, resp0_ready};
    qv = {req1_valid, req0_valid};
    qr = {req1_ready, req0_ready};
    if (rst) begin
      prev_rv = 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (qv[k] && qr[k]) begin
          exp_t         e;
          logic [W-1:0] d;
          d         = (k == 1) ? req1_data : req0_data;
          e.ctx     = (k == 1);
          e.data    = d + m_st[k] - 8'd1;
          e.cont    = (d != 8'hFF);
          e.acc_cyc = cyc;
          sb.push_back(e);
          gnt_log.push_back(k);
          n_accept++;
          m_st[k] = m_st[k] ^ d;
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (rv[k]) begin
          logic [W-1:0] ad;
          logic         ac;
          ad = (k == 1) ? resp1_data : resp0_data;
          ac = (k == 1) ? resp1_cont : resp0_cont;
          n_tests++;
          if (sb.size() == 0 || sb[0].ctx != (k == 1)) begin
            n_fail++;
            $display("FAIL resp_unexpected: resp%0d_valid=1 got, no pending response for it required", k);
          end else begin
            if (!prev_rv[k] && (cyc != sb[0].acc_cyc + 2)) begin
              n_fail++;
              $display("FAIL resp_latency ctx%0d: valid at cycle %0d got, %0d required", k, cyc, sb[0].acc_cyc + 2);
            end
            if (ad !== sb[0].data || ac !== sb[0].cont) begin
              n_fail++;
              $display("FAIL resp_data ctx%0d: data=%h cont=%b got, data=%h cont=%b required",
                       k, ad, ac, sb[0].data, sb[0].cont);
            end
            if (rr[k]) void'(sb.pop_front());
          end
        end
      end
      prev_rv = rv;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    gnt_log.delete();
    m_st[0] = 8'h01;
    m_st[1] = 8'h01;
  endtask

  // Present one request for context k and hold it until accepted.
  task automatic issue(input int k, input logic [W-1:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    if (k == 1) begin req1_valid = 1'b1; req1_data = d; end
    else        begin req0_valid = 1'b1; req0_data = d; end
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if ((k == 1) ? req1_ready : req0_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout ctx%0d: ready=0 got, ready=1 required", k);
    end
    @(posedge clk); #1;
    if (k == 1) req1_valid = 1'b0;
    else        req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || resp0_valid || resp1_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d pending got, 0 required", sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if (halted !== 2'b00 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: halted=%b rv=%b%b got, 00/00 required", halted, resp1_valid, resp0_valid);
    end
    n_tests++;
    if (dev_in !== 8'h00 || dev_st !== 8'h00 || resp0_data !== 8'h00 || resp1_cont !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: dev_in=%h dev_st=%h resp0_data=%h got, 00 required", dev_in, dev_st, resp0_data);
    end
    n_tests++;
    if (dut.r_st[0] !== 8'h01 || dut.r_st[1] !== 8'h01) begin
      n_fail++;
      $display("FAIL reset_state: st0=%h st1=%h got, 01/01 required", dut.r_st[0], dut.r_st[1]);
    end
    n_tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: ready=%b%b got, 00 required", req1_ready, req0_ready);
    end
  endtask

  task automatic test_basic();
    issue(0, 8'h01);
    wait_drain();
    n_tests++;
    if (dut.r_st[0] !== 8'h00 || dut.r_st[1] !== 8'h01) begin
      n_fail++;
      $display("FAIL basic_state: st0=%h st1=%h got, 00/01 required", dut.r_st[0], dut.r_st[1]);
    end
    issue(1, 8'h3C);
    issue(0, 8'h81);
    wait_drain();
    n_tests++;
    if (dut.r_st[0] !== m_st[0] || dut.r_st[1] !== m_st[1]) begin
      n_fail++;
      $display("FAIL basic_state2: st0=%h st1=%h got, %h/%h required", dut.r_st[0], dut.r_st[1], m_st[0], m_st[1]);
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    do_reset();
    @(posedge clk); #1;
    req0_data  = 8'h12;
    req1_data  = 8'h34;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    while (gnt_log.size() < 4 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (gnt_log.size() <= i) begin
        n_fail++;
        $display("FAIL rr_grant%0d: no grant got, ctx%0d required", i, i % 2);
      end else if (gnt_log[i] != i % 2) begin
        n_fail++;
        $display("FAIL rr_grant%0d: ctx%0d got, ctx%0d required", i, gnt_log[i], i % 2);
      end
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int           acc_before;
    int           n = 0;
    logic [W-1:0] held;
    resp0_ready = 1'b0;
    issue(0, 8'h5A);
    req0_data  = 8'h21;
    req1_data  = 8'h43;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    acc_before = n_accept;
    while (!resp0_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    held = (sb.size() != 0) ? sb[0].data : 8'hxx;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (resp0_valid !== 1'b1 || resp0_data !== held || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b data=%h rdy=%b%b got, valid=1 data=%h rdy=00 required",
                 i, resp0_valid, resp0_data, req1_ready, req0_ready, held);
      end
    end
    n_tests++;
    if (n_accept != acc_before) begin
      n_fail++;
      $display("FAIL bp_no_accept: %0d acceptances got, 0 required", n_accept - acc_before);
    end
    @(posedge clk); #1;
    resp0_ready = 1'b1;
    n = 0;
    while (n_accept == acc_before && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_tests++;
    if (n_accept != acc_before + 1 || gnt_log[gnt_log.size()-1] != 1) begin
      n_fail++;
      $display("FAIL bp_next_grant: %0d acceptances last ctx%0d got, 1 acceptance ctx1 required",
               n_accept - acc_before, gnt_log[gnt_log.size()-1]);
    end
    wait_drain();
  endtask

  task automatic test_halt();
    issue(1, 8'hFF);
    wait_drain();
    n_tests++;
    if (halted !== 2'b10) begin
      n_fail++;
      $display("FAIL halt_flag: halted=%b got, 10 required", halted);
    end
    @(posedge clk); #1;
    req1_data  = 8'h11;
    req1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_ready%0d: req1_ready=%b got, 0 required", i, req1_ready);
      end
    end
    issue(0, 8'h33);
    issue(0, 8'h07);
    wait_drain();
    req1_valid = 1'b0;
    n_tests++;
    if (dut.r_st[1] !== m_st[1] || dut.r_st[0] !== m_st[0] || halted !== 2'b10) begin
      n_fail++;
      $display("FAIL halt_state: st0=%h st1=%h halted=%b got, %h/%h/10 required",
               dut.r_st[0], dut.r_st[1], halted, m_st[0], m_st[1]);
    end
  endtask

  task automatic test_reset_mid_step();
    int n = 0;
    issue(0, 8'h0F);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    gnt_log.delete();
    m_st[0] = 8'h01;
    m_st[1] = 8'h01;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_resp%0d: rv=%b%b got, 00 required", i, resp1_valid, resp0_valid);
      end
    end
    n_tests++;
    if (dut.r_st[0] !== 8'h01 || dut.r_st[1] !== 8'h01 || halted !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_state: st0=%h st1=%h halted=%b got, 01/01/00 required", dut.r_st[0], dut.r_st[1], halted);
    end
    @(posedge clk); #1;
    req0_data  = 8'h55;
    req1_data  = 8'h66;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    while (gnt_log.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_tests++;
    if (gnt_log.size() == 0 || gnt_log[0] != 0) begin
      n_fail++;
      $display("FAIL abort_first_grant: ctx%0d got, ctx0 required", (gnt_log.size() == 0) ? -1 : gnt_log[0]);
    end
    wait_drain();
  endtask

`ifdef RW_CTX_SCHED_STATS_EN
  task automatic test_stats();
    logic [CNT_W-1:0] exp_cnt[3];
    exp_cnt[0] = 16'hFFFE;
    exp_cnt[1] = 16'hFFFF;
    exp_cnt[2] = 16'h0000;
    do_reset();
    @(negedge clk);
    dut.r_step_cnt0 = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      issue(0, 8'h02);
      wait_drain();
      n_tests++;
      if (step_cnt0 !== exp_cnt[i] || step_cnt1 !== 16'h0000) begin
        n_fail++;
        $display("FAIL stats_cnt%0d: cnt0=%h cnt1=%h got, %h/0000 required", i, step_cnt0, step_cnt1, exp_cnt[i]);
      end
    end
  endtask
`endif

  initial begin
    m_st[0] = 8'h01;
    m_st[1] = 8'h01;
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_halt();
    test_reset_mid_step();
`ifdef RW_CTX_SCHED_STATS_EN
    test_stats();
`endif
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: %0d pending got, 0 required", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
